load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of BUSY cycles spent waiting for bus_ack.
REQ-002 SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 control_mem_read  in  1  load request from the decode stage.
REQ-006 control_mem_write  in  1  store request from the decode stage.
REQ-007 funct3  in  3  access size and signedness.
REQ-008 addr  in  32  byte address.
REQ-009 store_data  in  32  store operand (rf2).
REQ-010 stall  out  1  holds the pipeline.
REQ-011 load_data  out  32  extended load result.
REQ-012 load_valid  out  1  load-result strobe.
REQ-013 misaligned  out  1  alignment-exception strobe.
REQ-014 access_fault  out  1  fault strobe.
REQ-015 bus_req, bus_we  out  1 each  bus request and write select.
REQ-016 bus_addr  out  32  word address with [1:0] = 0.
REQ-017 bus_wdata  out  32  write data.
REQ-018 bus_be  out  4  byte enables.
REQ-019 bus_ack, bus_err  in  1 each  bus response.
REQ-020 bus_rdata  in  32  read data.

Function
REQ-021 SHALL implement a three-state FSM: IDLE, BUSY and DONE.
REQ-022 IDLE, exactly one of read or write asserted, aligned and legal: SHALL latch addr, funct3, store_data and direction, go to BUSY, and drive stall=1 combinationally in this cycle.
REQ-023 Legal loads: LB=000, LH=001, LW=010, LBU=100, LHU=101. Legal stores: SB=000, SH=001, SW=010. Any other funct3 SHALL pulse access_fault for one cycle, stay in IDLE, issue no bus access and keep stall=0.
REQ-024 Read and write both asserted SHALL be treated as in REQ-023: access_fault pulse, no bus access.
REQ-025 Misalignment (H with addr[0]=1; W with addr[1:0]!=0) SHALL pulse misaligned for one cycle, stay in IDLE, issue no bus access and keep stall=0.
REQ-026 BUSY: bus_req SHALL be 1 and bus_addr, bus_we, bus_be and bus_wdata SHALL stay stable until bus_ack or timeout; stall=1.
REQ-027 Byte enables SHALL be: B -> 4'b0001<<addr[1:0]; H -> 4'b0011<<addr[1:0]; W -> 4'b1111.
REQ-028 bus_wdata SHALL be replicated: SB {4{b}}, SH {2{h}}, SW as is.
REQ-029 bus_ack=1 in BUSY SHALL capture bus_rdata and move to DONE; bus_req SHALL deassert in DONE.
REQ-030 Load extraction SHALL select the byte lane by addr[1:0] and the half lane by addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-031 DONE SHALL last one cycle with stall=0, then return to IDLE; in DONE the unit SHALL ignore request inputs.
REQ-032 In DONE for a load, load_valid SHALL be 1 and load_data SHALL hold the extended value; load_data SHALL be held until the next load completes.
REQ-033 If bus_err=1 with bus_ack: DONE with access_fault=1, load_valid=0, load_data unchanged.
REQ-034 A timeout counter SHALL run in BUSY; no ack after TIMEOUT_CYCLES cycles SHALL drop bus_req and enter DONE with access_fault=1; the counter SHALL clear on entry to BUSY.
REQ-035 Zero-wait-state latency SHALL be: accept cycle (stall=1), BUSY with ack (stall=1), DONE (stall=0), i.e. 2 stall cycles.
REQ-036 Bus inputs outside BUSY SHALL be ignored.

Reset
REQ-037 rst SHALL force IDLE immediately, independent of clk.
REQ-038 During reset, all outputs SHALL be 0: stall, load_valid, misaligned, access_fault, bus_req, bus_we, bus_be, bus_addr, bus_wdata and load_data.
REQ-039 Reset during BUSY SHALL abandon the transaction with no fault strobe after release.

Structure
REQ-040 The lsu_state_t enum, the load/store funct3 constants (LB..LHU, SB..SW) and the access-size type SHALL live in package common.
REQ-041 Lane extraction and sign extension SHALL be one combinational sub-module, load_extend.

Verification
REQ-042 LW addr=0x100, ack on first BUSY cycle, rdata=0xDEADBEEF -> bus_addr=0x100, be=1111, stall high 2 cycles, load_data=0xDEADBEEF.
REQ-043 LB addr=0x203, rdata=0x80FF7F01 -> be=1000, load_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-044 SH addr=0x302, store_data=0x1234ABCD -> bus_we=1, be=1100, wdata=0xABCDABCD, load_valid=0.
REQ-045 LW addr=0x101 -> misaligned pulse, no bus_req, stall=0; funct3=011 load -> access_fault pulse.
REQ-046 LW with no ack for 16 cycles -> bus_req drops, access_fault=1 in DONE; bus_err with ack -> access_fault, load_data unchanged.
REQ-047 rst asserted in the 3rd BUSY cycle -> bus_req=0 and stall=0 immediately; the next LW completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared declarations for the load/store unit: FSM states, funct3 encodings,
// access sizes and the byte-enable helper.
package common;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } lsu_state_t;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } access_size_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // funct3[1:0] encodes the size for both loads and stores; [2] is only signedness.
  function automatic access_size_t size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SIZE_B;
      2'b01:   return SIZE_H;
      default: return SIZE_W;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input access_size_t size, input logic [1:0] offset);
    case (size)
      SIZE_B:  return 4'b0001 << offset;
      SIZE_H:  return 4'b0011 << offset;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Picks the addressed byte/half lane out of a bus read word and extends it
// to 32 bits according to the load funct3.
module load_extend
  import common::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata_i[8*offset_i +: 8];
    lane_h = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      LB:      data_o = {{24{lane_b[7]}}, lane_b};
      LBU:     data_o = {24'b0, lane_b};
      LH:      data_o = {{16{lane_h[15]}}, lane_h};
      LHU:     data_o = {16'b0, lane_h};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: validates decode-stage memory requests, runs one bus
// transaction at a time with a timeout, and returns extended load data.
module load_store_unit
  import common::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        control_mem_read,
  input  logic        control_mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        access_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  lsu_state_t    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   sdata_q, sdata_d;
  logic [31:0]   load_data_q, load_data_d;
  logic [2:0]    funct3_q, funct3_d;
  logic          we_q, we_d;
  logic          fault_q, fault_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          req_one, req_both, f3_legal, aligned;
  access_size_t  req_size, cur_size;
  logic [31:0]   extended;

  load_extend u_load_extend (
    .rdata_i  (bus_rdata),
    .offset_i (addr_q[1:0]),
    .funct3_i (funct3_q),
    .data_o   (extended)
  );

  always_comb begin
    req_one  = control_mem_read ^ control_mem_write;
    req_both = control_mem_read & control_mem_write;
    req_size = size_of(funct3);
    if (control_mem_write) begin
      f3_legal = (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
    end else begin
      f3_legal = (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
                 (funct3 == LBU) || (funct3 == LHU);
    end
    case (req_size)
      SIZE_H:  aligned = ~addr[0];
      SIZE_W:  aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  // Next-state and outputs; bus signals are driven only while BUSY so they
  // stay frozen on the latched request until ack or timeout.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    sdata_d      = sdata_q;
    funct3_d     = funct3_q;
    we_d         = we_q;
    fault_d      = fault_q;
    timer_d      = timer_q;
    load_data_d  = load_data_q;
    cur_size     = size_of(funct3_q);
    stall        = 1'b0;
    load_valid   = 1'b0;
    misaligned   = 1'b0;
    access_fault = 1'b0;
    bus_req      = 1'b0;
    bus_we       = 1'b0;
    bus_addr     = '0;
    bus_wdata    = '0;
    bus_be       = '0;

    case (state_q)
      IDLE: begin
        if (req_both) begin
          access_fault = 1'b1;
        end else if (req_one) begin
          if (!f3_legal) begin
            access_fault = 1'b1;
          end else if (!aligned) begin
            misaligned = 1'b1;
          end else begin
            stall    = 1'b1;
            addr_d   = addr;
            sdata_d  = store_data;
            funct3_d = funct3;
            we_d     = control_mem_write;
            fault_d  = 1'b0;
            timer_d  = '0;
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        stall    = 1'b1;
        bus_req  = 1'b1;
        bus_we   = we_q;
        bus_addr = {addr_q[31:2], 2'b00};
        bus_be   = byte_enables(cur_size, addr_q[1:0]);
        case (cur_size)
          SIZE_B:  bus_wdata = {4{sdata_q[7:0]}};
          SIZE_H:  bus_wdata = {2{sdata_q[15:0]}};
          default: bus_wdata = sdata_q;
        endcase
        if (bus_ack) begin
          state_d = DONE;
          fault_d = bus_err;
          if (!we_q && !bus_err) begin
            load_data_d = extended;
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d = DONE;
          fault_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DONE: begin
        access_fault = fault_q;
        load_valid   = ~we_q & ~fault_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The IDLE strobes follow the request inputs, so hold them low while in reset.
    if (rst) begin
      stall        = 1'b0;
      misaligned   = 1'b0;
      access_fault = 1'b0;
    end
  end

  assign load_data = load_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      sdata_q     <= '0;
      funct3_q    <= '0;
      we_q        <= 1'b0;
      fault_q     <= 1'b0;
      timer_q     <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      funct3_q    <= funct3_d;
      we_q        <= we_d;
      fault_q     <= fault_d;
      timer_q     <= timer_d;
      load_data_q <= load_data_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed cases plus randomized requests
// compared against a byte-lane reference model of the memory access rules.
module tb_load_store_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        control_mem_read = 1'b0;
  logic        control_mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misaligned;
  logic        access_fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic        bus_err = 1'b0;
  logic [31:0] bus_rdata = '0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] modelLoad = '0;

  load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk               (clk),
    .rst               (rst),
    .control_mem_read  (control_mem_read),
    .control_mem_write (control_mem_write),
    .funct3            (funct3),
    .addr              (addr),
    .store_data        (store_data),
    .stall             (stall),
    .load_data         (load_data),
    .load_valid        (load_valid),
    .misaligned        (misaligned),
    .access_fault      (access_fault),
    .bus_req           (bus_req),
    .bus_we            (bus_we),
    .bus_addr          (bus_addr),
    .bus_wdata         (bus_wdata),
    .bus_be            (bus_be),
    .bus_ack           (bus_ack),
    .bus_err           (bus_err),
    .bus_rdata         (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference model: access width in bytes, legality and lane arithmetic.
  function automatic int sizeBytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit isLegal(input logic rd, input logic wr, input logic [2:0] f3);
    if (rd && wr) return 1'b0;
    if (wr) return f3 <= 3'd2;
    return (f3 != 3'd3) && (f3 <= 3'd5);
  endfunction

  function automatic logic [3:0] expectBe(input int n, input logic [31:0] a);
    if (n == 4) return 4'hF;
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] expectWdata(input int n, input logic [31:0] sd);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'(sd >> (8 * (i % n)));
    return w;
  endfunction

  function automatic logic [31:0] expectLoad(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int n = sizeBytes(f3);
    int off = (n == 2) ? 2 * int'(a[1]) : int'(a[1:0]);
    logic [31:0] mask;
    logic [31:0] value;
    if (n == 4) return rd;
    mask = (32'h1 << (8 * n)) - 32'h1;
    value = (rd >> (8 * off)) & mask;
    if (!f3[2] && value[8*n-1]) value = value | ~mask;
    return value;
  endfunction

  task automatic clearRequest();
    control_mem_read = 1'b0;
    control_mem_write = 1'b0;
    funct3 = '0;
    addr = '0;
    store_data = '0;
  endtask

  // One complete request. ackAt is the BUSY cycle index carrying bus_ack (-1: never).
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] sd,
                               input int ackAt, input logic err, input logic [31:0] rdata);
    int n = sizeBytes(f3);
    bit legal = isLegal(rd, wr, f3);
    bit aligned = (a % n) == 0;
    bit acked = 1'b0;
    bit expFault;
    @(negedge clk);
    control_mem_read = rd;
    control_mem_write = wr;
    funct3 = f3;
    addr = a;
    store_data = sd;
    #1;
    if (!legal || !aligned) begin
      checkOutput("reject_fault", access_fault, !legal);
      checkOutput("reject_misaligned", misaligned, legal && !aligned);
      checkOutput("reject_stall", stall, 0);
      checkOutput("reject_bus_req", bus_req, 0);
      @(posedge clk); #1;
      clearRequest();
      #1;
      checkOutput("reject_after_fault", access_fault, 0);
      checkOutput("reject_after_misaligned", misaligned, 0);
      checkOutput("reject_after_bus_req", bus_req, 0);
      return;
    end
    checkOutput("accept_stall", stall, 1);
    checkOutput("accept_bus_req", bus_req, 0);
    @(posedge clk); #1;
    clearRequest();
    for (int c = 0; c < TIMEOUT; c++) begin
      checkOutput("busy_req", bus_req, 1);
      checkOutput("busy_stall", stall, 1);
      checkOutput("busy_addr", bus_addr, a & ~32'h3);
      checkOutput("busy_we", bus_we, wr);
      checkOutput("busy_be", bus_be, expectBe(n, a));
      if (wr) checkOutput("busy_wdata", bus_wdata, expectWdata(n, sd));
      if (c == ackAt) begin
        bus_ack = 1'b1;
        bus_err = err;
        bus_rdata = rdata;
      end else begin
        bus_rdata = $urandom;
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
      bus_err = 1'b0;
      if (c == ackAt) begin
        acked = 1'b1;
        break;
      end
    end
    expFault = !acked || err;
    if (rd && !expFault) modelLoad = expectLoad(f3, a, rdata);
    checkOutput("done_stall", stall, 0);
    checkOutput("done_bus_req", bus_req, 0);
    checkOutput("done_fault", access_fault, expFault);
    checkOutput("done_load_valid", load_valid, rd && !expFault);
    checkOutput("done_load_data", load_data, modelLoad);
    @(posedge clk); #1;
    checkOutput("idle_fault", access_fault, 0);
    checkOutput("idle_load_valid", load_valid, 0);
    checkOutput("idle_stall", stall, 0);
    checkOutput("idle_load_data", load_data, modelLoad);
  endtask

  initial begin
    // A pending request during reset must not leak onto any output.
    control_mem_read = 1'b1;
    funct3 = 3'b010;
    addr = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_load_valid", load_valid, 0);
    checkOutput("rst_misaligned", misaligned, 0);
    checkOutput("rst_fault", access_fault, 0);
    checkOutput("rst_bus_req", bus_req, 0);
    checkOutput("rst_bus_we", bus_we, 0);
    checkOutput("rst_bus_be", bus_be, 0);
    checkOutput("rst_bus_addr", bus_addr, 0);
    checkOutput("rst_bus_wdata", bus_wdata, 0);
    checkOutput("rst_load_data", load_data, 0);
    clearRequest();
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(1, 0, 3'b010, 32'h100, 0, 0, 0, 32'hDEADBEEF);
    checkOutput("lw_value", load_data, 32'hDEADBEEF);
    applyStimulus(1, 0, 3'b000, 32'h203, 0, 1, 0, 32'h80FF7F01);
    checkOutput("lb_value", load_data, 32'hFFFFFF80);
    applyStimulus(1, 0, 3'b100, 32'h203, 0, 0, 0, 32'h80FF7F01);
    checkOutput("lbu_value", load_data, 32'h00000080);
    applyStimulus(1, 0, 3'b001, 32'h302, 0, 0, 0, 32'h8001_7FFF);
    applyStimulus(1, 0, 3'b101, 32'h300, 0, 2, 0, 32'h8001_9ABC);
    applyStimulus(0, 1, 3'b001, 32'h302, 32'h1234ABCD, 0, 0, 0);
    applyStimulus(0, 1, 3'b000, 32'h301, 32'h000000A5, 1, 0, 0);
    applyStimulus(0, 1, 3'b010, 32'h308, 32'hCAFEF00D, 0, 0, 0);
    checkOutput("store_keeps_load", load_data, 32'h00009ABC);

    applyStimulus(1, 0, 3'b010, 32'h101, 0, 0, 0, 0);
    applyStimulus(1, 0, 3'b001, 32'h103, 0, 0, 0, 0);
    applyStimulus(1, 0, 3'b011, 32'h100, 0, 0, 0, 0);
    applyStimulus(0, 1, 3'b100, 32'h100, 0, 0, 0, 0);
    applyStimulus(1, 1, 3'b010, 32'h100, 0, 0, 0, 0);

    applyStimulus(1, 0, 3'b010, 32'h500, 0, -1, 0, 0);
    applyStimulus(1, 0, 3'b010, 32'h504, 0, 0, 1, 32'h11111111);
    checkOutput("err_keeps_load", load_data, 32'h00009ABC);
    applyStimulus(1, 0, 3'b010, 32'h508, 0, TIMEOUT - 1, 0, 32'h0BADCAFE);

    // Reset lands in the third BUSY cycle of a load that never gets acked.
    @(negedge clk);
    control_mem_read = 1'b1;
    funct3 = 3'b010;
    addr = 32'h400;
    @(posedge clk); #1;
    clearRequest();
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("busy3_bus_req", bus_req, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_bus_req", bus_req, 0);
    checkOutput("midrst_stall", stall, 0);
    checkOutput("midrst_load_data", load_data, 0);
    modelLoad = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("postrst_fault", access_fault, 0);
    checkOutput("postrst_bus_req", bus_req, 0);
    applyStimulus(1, 0, 3'b010, 32'h404, 0, 0, 0, 32'h13572468);

    for (int t = 0; t < 40; t++) begin
      int kind = $urandom_range(0, 9);
      int w = $urandom_range(0, 9);
      logic rd = (kind == 0) || (kind <= 5);
      logic wr = (kind == 0) || (kind >= 6);
      applyStimulus(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom,
                    (w == 9) ? -1 : (w % 4), ($urandom_range(0, 7) == 0), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
